// File: rtl/cpu6_trap_ctrl_pkg.sv
// rtl/cpu6_trap_ctrl_pkg.sv - shared widths, state encodings and cause codes for the cpu6 trap sequencer
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN        = 32;
  localparam int CPU6_TRAPST_SIZE = 3;

  typedef enum logic [CPU6_TRAPST_SIZE-1:0] {
    CPU6_TRAPST_IDLE    = 3'd0,
    CPU6_TRAPST_TDRAIN  = 3'd1,
    CPU6_TRAPST_TCOMMIT = 3'd2,
    CPU6_TRAPST_RDRAIN  = 3'd3,
    CPU6_TRAPST_RCOMMIT = 3'd4
  } trap_state_e;

  localparam logic CPU6_CAUSE_TMR = 1'b0;
  localparam logic CPU6_CAUSE_EXT = 1'b1;

  function automatic logic irq_pending(input logic mie, input logic mtie,
                                       input logic tmr, input logic ext);
    return mie & (ext | (tmr & mtie));
  endfunction

endpackage

// File: rtl/cpu6_trap_drain_cnt.sv
// rtl/cpu6_trap_drain_cnt.sv - drain timeout counter with clear/enable and an expiry flag
module cpu6_trap_drain_cnt #(
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the DRAIN_TIMEOUT-th enabled cycle, so the count lands on DRAIN_TIMEOUT at the commit edge.
  assign expired_o = en_i & (cnt_q == CW'(DRAIN_TIMEOUT - 1));

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// rtl/cpu6_trap_ctrl.sv - interrupt entry / mret return sequencer: drain pipeline, then redirect PC
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN          = CPU6_XLEN,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validE,
  input  logic [XLEN-1:0] pcE,
  input  logic            mret_reqE,
  input  logic            tmr_irq_r,
  input  logic            ext_irq_r,
  input  logic            csr_mtie_r,
  input  logic            csr_mstatus_mie_r,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            empty_pipeline_ackW,
  output logic            empty_pipeline_reqE,
  output logic            stallF,
  output logic            killE,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic            mret_ena,
  output logic            excp_cause,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            drain_err
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            cause_q, cause_d;
  logic            drain_err_q, drain_err_d;

  logic irq_pend;
  logic take_trap;
  logic take_mret;
  logic draining;
  logic expired;

  assign irq_pend  = irq_pending(csr_mstatus_mie_r, csr_mtie_r, tmr_irq_r, ext_irq_r);
  // Gated by reset so every output reads 0 while reset is held, even with live inputs.
  assign take_trap = reset & validE & irq_pend;
  assign take_mret = reset & validE & mret_reqE & ~irq_pend;
  assign draining  = (state_q == CPU6_TRAPST_TDRAIN) || (state_q == CPU6_TRAPST_RDRAIN);

  cpu6_trap_drain_cnt #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (~draining),
    .en_i     (draining),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CPU6_TRAPST_IDLE;
      mepc_q      <= '0;
      cause_q     <= CPU6_CAUSE_TMR;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mepc_q      <= mepc_d;
      cause_q     <= cause_d;
      drain_err_q <= drain_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mepc_d      = mepc_q;
    cause_d     = cause_q;
    drain_err_d = drain_err_q;
    case (state_q)
      CPU6_TRAPST_IDLE: begin
        if (take_trap) begin
          // A simultaneous mret loses; saving its PC makes it re-execute after the handler.
          state_d = CPU6_TRAPST_TDRAIN;
          mepc_d  = pcE;
          cause_d = ext_irq_r ? CPU6_CAUSE_EXT : CPU6_CAUSE_TMR;
        end else if (take_mret) begin
          state_d = CPU6_TRAPST_RDRAIN;
        end
      end
      CPU6_TRAPST_TDRAIN, CPU6_TRAPST_RDRAIN: begin
        if (empty_pipeline_ackW || expired) begin
          state_d = (state_q == CPU6_TRAPST_TDRAIN) ? CPU6_TRAPST_TCOMMIT : CPU6_TRAPST_RCOMMIT;
          if (!empty_pipeline_ackW) begin
            drain_err_d = 1'b1;
          end
        end
      end
      CPU6_TRAPST_TCOMMIT, CPU6_TRAPST_RCOMMIT: state_d = CPU6_TRAPST_IDLE;
      default:                                  state_d = CPU6_TRAPST_IDLE;
    endcase
  end

  always_comb begin
    empty_pipeline_reqE = 1'b0;
    stallF              = 1'b0;
    killE               = 1'b0;
    excp_mepc           = '0;
    excp_mepc_ena       = 1'b0;
    mret_ena            = 1'b0;
    excp_cause          = CPU6_CAUSE_TMR;
    trap_redirect       = 1'b0;
    trap_pc             = '0;
    case (state_q)
      CPU6_TRAPST_IDLE: begin
        if (take_trap || take_mret) begin
          empty_pipeline_reqE = 1'b1;
          stallF              = 1'b1;
          killE               = 1'b1;
        end
      end
      CPU6_TRAPST_TDRAIN, CPU6_TRAPST_RDRAIN: begin
        stallF = 1'b1;
        killE  = 1'b1;
      end
      CPU6_TRAPST_TCOMMIT: begin
        stallF        = 1'b1;
        excp_mepc_ena = 1'b1;
        excp_mepc     = mepc_q;
        excp_cause    = cause_q;
        trap_redirect = 1'b1;
        trap_pc       = csr_mtvec;
      end
      CPU6_TRAPST_RCOMMIT: begin
        stallF        = 1'b1;
        mret_ena      = 1'b1;
        trap_redirect = 1'b1;
        trap_pc       = csr_mepc;
      end
      default: ;
    endcase
  end

  assign drain_err = drain_err_q;

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// tb/tb_cpu6_trap_ctrl.sv - self-checking bench for cpu6_trap_ctrl with a commit scoreboard
module tb_cpu6_trap_ctrl;

  logic        clk;
  logic        reset;
  logic        validE;
  logic [31:0] pcE;
  logic        mret_reqE;
  logic        tmr_irq_r, ext_irq_r;
  logic        csr_mtie_r, csr_mstatus_mie_r;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        empty_pipeline_ackW;
  logic        empty_pipeline_reqE;
  logic        stallF, killE;
  logic [31:0] excp_mepc;
  logic        excp_mepc_ena, mret_ena, excp_cause;
  logic        trap_redirect;
  logic [31:0] trap_pc;
  logic        drain_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        is_trap;
    logic [31:0] mepc;
    logic        cause;
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic ack_en, ack_force, req_d1, req_d2;

  cpu6_trap_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .validE             (validE),
    .pcE                (pcE),
    .mret_reqE          (mret_reqE),
    .tmr_irq_r          (tmr_irq_r),
    .ext_irq_r          (ext_irq_r),
    .csr_mtie_r         (csr_mtie_r),
    .csr_mstatus_mie_r  (csr_mstatus_mie_r),
    .csr_mtvec          (csr_mtvec),
    .csr_mepc           (csr_mepc),
    .empty_pipeline_ackW(empty_pipeline_ackW),
    .empty_pipeline_reqE(empty_pipeline_reqE),
    .stallF             (stallF),
    .killE              (killE),
    .excp_mepc          (excp_mepc),
    .excp_mepc_ena      (excp_mepc_ena),
    .mret_ena           (mret_ena),
    .excp_cause         (excp_cause),
    .trap_redirect      (trap_redirect),
    .trap_pc            (trap_pc),
    .drain_err          (drain_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Nominal pipeline: the drain marker injected in EX reaches WB two cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_d1 <= 1'b0;
      req_d2 <= 1'b0;
    end else begin
      req_d1 <= empty_pipeline_reqE;
      req_d2 <= req_d1;
    end
  end
  assign empty_pipeline_ackW = (ack_en & req_d2) | ack_force;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && trap_redirect) begin
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_redirect: observed trap_pc %0h expected no redirect", trap_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_cycle", 64'(cyc), 64'(e.cyc));
        chk("trap_pc", 64'(trap_pc), 64'(e.pc));
        chk("excp_mepc_ena", 64'(excp_mepc_ena), 64'(e.is_trap));
        chk("mret_ena", 64'(mret_ena), 64'(!e.is_trap));
        chk("commit_stallF", 64'(stallF), 64'd1);
        if (e.is_trap) begin
          chk("excp_mepc", 64'(excp_mepc), 64'(e.mepc));
          chk("excp_cause", 64'(excp_cause), 64'(e.cause));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted instruction for a cycle, checks the accept-cycle outputs, returns at t+1.
  task automatic accept(input logic [31:0] pc, input logic is_trap, input logic cause,
                        input logic [31:0] tgt, input int lat, input logic push);
    exp_t e;
    validE = 1'b1;
    pcE    = pc;
    if (push) begin
      e.is_trap = is_trap;
      e.mepc    = pc;
      e.cause   = cause;
      e.pc      = tgt;
      e.cyc     = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("accept_killE", 64'(killE), 64'd1);
    chk("accept_reqE", 64'(empty_pipeline_reqE), 64'd1);
    chk("accept_stallF", 64'(stallF), 64'd1);
    tick();
    validE    = 1'b0;
    mret_reqE = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reqE"}, 64'(empty_pipeline_reqE), 64'd0);
    chk({tag, "_stallF"}, 64'(stallF), 64'd0);
    chk({tag, "_killE"}, 64'(killE), 64'd0);
    chk({tag, "_strobes"}, 64'({excp_mepc_ena, mret_ena, trap_redirect, excp_cause}), 64'd0);
    chk({tag, "_data"}, 64'({excp_mepc, trap_pc}), 64'd0);
    chk({tag, "_drain_err"}, 64'(drain_err), 64'd0);
  endtask

  initial begin
    reset = 1'b0; validE = 1'b0; pcE = '0; mret_reqE = 1'b0;
    tmr_irq_r = 1'b0; ext_irq_r = 1'b0; csr_mtie_r = 1'b0; csr_mstatus_mie_r = 1'b0;
    csr_mtvec = 32'h80; csr_mepc = '0; ack_en = 1'b1; ack_force = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();

    // Timer interrupt: stallF high t..t+3, commit at t+3
    csr_mstatus_mie_r = 1'b1; csr_mtie_r = 1'b1; tmr_irq_r = 1'b1;
    accept(32'h100, 1'b1, 1'b0, 32'h80, 3, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("tmr_stallF", 64'(stallF), 64'(i <= 3));
      if (i <= 2) begin
        chk("drain_killE", 64'(killE), 64'd1);
        chk("drain_reqE", 64'(empty_pipeline_reqE), 64'd0);
      end
      tick();
    end
    tmr_irq_r = 1'b0;
    wait_idle();

    // External with mie=0, then pending with validE=0: neither acted on
    csr_mstatus_mie_r = 1'b0; ext_irq_r = 1'b1; validE = 1'b1; pcE = 32'h140;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mie0_stallF", 64'(stallF), 64'd0);
      chk("mie0_killE", 64'(killE), 64'd0);
      tick();
    end
    validE = 1'b0; csr_mstatus_mie_r = 1'b1;
    @(negedge clk);
    chk("novalid_stallF", 64'(stallF), 64'd0);
    tick();
    accept(32'h140, 1'b1, 1'b1, 32'h80, 3, 1'b1);
    wait_idle();

    // Both pending: external wins
    tmr_irq_r = 1'b1;
    accept(32'h180, 1'b1, 1'b1, 32'h80, 3, 1'b1);
    wait_idle();
    tmr_irq_r = 1'b0; ext_irq_r = 1'b0;

    // mret, interrupt raised during RDRAIN is taken afterwards
    csr_mepc = 32'h204; mret_reqE = 1'b1;
    accept(32'h250, 1'b0, 1'b0, 32'h204, 3, 1'b1);
    ext_irq_r = 1'b1;
    wait_idle();
    accept(32'h260, 1'b1, 1'b1, 32'h80, 3, 1'b1);
    wait_idle();
    ext_irq_r = 1'b0;

    // mret and interrupt together: trap path, mepc is the mret PC
    csr_mepc = 32'h999; mret_reqE = 1'b1; tmr_irq_r = 1'b1;
    accept(32'h300, 1'b1, 1'b0, 32'h80, 3, 1'b1);
    wait_idle();

    // Stale ack in the accept cycle must not shorten the drain
    ack_force = 1'b1;
    accept(32'h340, 1'b1, 1'b0, 32'h80, 3, 1'b1);
    ack_force = 1'b0;
    wait_idle();
    chk("no_err_yet", 64'(drain_err), 64'd0);

    // No ack: forced commit after 15 drain cycles, sticky error
    ack_en = 1'b0;
    csr_mtvec = 32'h88;
    accept(32'h380, 1'b1, 1'b0, 32'h88, 16, 1'b1);
    wait_idle();
    chk("timeout_err", 64'(drain_err), 64'd1);
    ack_en = 1'b1;
    accept(32'h390, 1'b1, 1'b0, 32'h88, 3, 1'b1);
    wait_idle();
    chk("err_sticky", 64'(drain_err), 64'd1);

    // Reset during TDRAIN aborts with no strobes
    accept(32'h3c0, 1'b1, 1'b0, 32'h88, 3, 1'b0);
    tmr_irq_r = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_redirect", 64'(trap_redirect), 64'd0);
      chk("post_reset_stallF", 64'(stallF), 64'd0);
      tick();
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu6_trap_ctrl.md
# cpu6_trap_ctrl

Sequencer for interrupt entry and `mret` return in the cpu6 core. Sits beside the cpu6 datapath and drives its `empty_pipeline_reqE` / `empty_pipeline_ackW`, `excp_mepc` / `excp_mepc_ena` and `mret_ena` ports. Before any control transfer it drains the EX/MEM/WB pipeline, then redirects the PC to `csr_mtvec` (trap) or `csr_mepc` (return). Fetch is held throughout.

## Interface
Parameters:
- `XLEN`, default `CPU6_XLEN` (32): address/data width.
- `DRAIN_TIMEOUT`, default 15: maximum DRAIN cycles before a forced commit; counter width is `$clog2(DRAIN_TIMEOUT+1)`.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `validE`  in  1  EX holds a real, not-squashed instruction.
- `pcE`  in  XLEN  PC of the EX instruction.
- `mret_reqE`  in  1  EX instruction decodes as `mret`.
- `tmr_irq_r`, `ext_irq_r`  in  1 each  registered interrupt lines.
- `csr_mtie_r`, `csr_mstatus_mie_r`  in  1 each  CSR enable bits.
- `csr_mtvec`, `csr_mepc`  in  XLEN  CSR values from the datapath.
- `empty_pipeline_ackW`  in  1  drain marker has reached WB.
- `empty_pipeline_reqE`  out  1  drain marker injected into EX.
- `stallF`  out  1  hold PC and fetch.
- `killE`  out  1  squash the EX instruction: no regwrite, no memwrite, no branch/jump.
- `excp_mepc`  out  XLEN  PC to save into `mepc`.
- `excp_mepc_ena`  out  1  one-cycle write strobe for `mepc`.
- `mret_ena`  out  1  one-cycle `mret` strobe to the CSR.
- `excp_cause`  out  1  1 = external interrupt, 0 = timer interrupt; valid while `excp_mepc_ena` is high.
- `trap_redirect`  out  1  one-cycle PC redirect strobe.
- `trap_pc`  out  XLEN  redirect target.
- `drain_err`  out  1  sticky flag: a drain timed out.

## Operation
- Pending interrupt: `irq_pend = csr_mstatus_mie_r & (ext_irq_r | (tmr_irq_r & csr_mtie_r))`. External interrupts have priority over timer interrupts.
- States: IDLE, TDRAIN, TCOMMIT, RDRAIN, RCOMMIT.
- IDLE
  - If `irq_pend & validE`: assert `killE`, `empty_pipeline_reqE` and `stallF` for this cycle. Latch `mepc_q <= pcE` and `cause_q <= ext_irq_r`. Go to TDRAIN.
  - Else if `mret_reqE & validE`: same kill/req/stall, go to RDRAIN.
  - An interrupt takes precedence over a simultaneous `mret`. In that case `mepc` becomes the `mret` PC, so the `mret` re-executes after the handler.
- TDRAIN / RDRAIN
  - `stallF=1` and `killE=1` (EX carries bubbles); `empty_pipeline_reqE=0`.
  - Counter increments every cycle.
  - On `empty_pipeline_ackW`, go to the matching COMMIT state.
  - When the counter reaches `DRAIN_TIMEOUT`, set `drain_err` and go to the matching COMMIT state anyway.
- TCOMMIT
  - `excp_mepc_ena=1`, `excp_mepc=mepc_q`, `excp_cause=cause_q`.
  - `trap_redirect=1`, `trap_pc=csr_mtvec`. `csr_mtvec` is sampled here, after the drain, so in-flight CSR writes are visible.
  - `stallF=1`. Go to IDLE.
- RCOMMIT
  - `mret_ena=1`, `trap_redirect=1`, `trap_pc=csr_mepc`, `stallF=1`. Go to IDLE.
- Interrupt changes after IDLE has been left are ignored until the controller returns to IDLE. The latched cause is kept.
- `irq_pend` or `mret_reqE` with `validE=0` is not acted on.

## Timing
- Reset values (asynchronous, while `reset=0`): state IDLE; `mepc_q`, `cause_q`, counter, `drain_err` = 0. All outputs 0.
- Reset asserted mid-sequence aborts it immediately: no strobe is emitted and the next state is IDLE.
- Latency, nominal pipeline:
  - Accept at cycle t.
  - `empty_pipeline_ackW` observed at t+2.
  - COMMIT at t+3, with `trap_redirect` high during t+3.
  - First handler fetch at t+4.
  - `stallF` is high from t through t+3 inclusive.
- `ackW` arriving in the accept cycle itself is ignored (it is stale).
- Every strobe is exactly one cycle. A new sequence cannot be accepted before the cycle after COMMIT.
- `drain_err` clears only on reset.
- Outputs are decoded combinationally from the state and registered data. No output has a combinational path from `empty_pipeline_ackW`.

## Structure
- Add to `defines.v`:
  - `CPU6_TRAPST_SIZE` (3) and `CPU6_TRAPST_IDLE/TDRAIN/TCOMMIT/RDRAIN/RCOMMIT` state encodings.
  - `CPU6_CAUSE_TMR` (0) and `CPU6_CAUSE_EXT` (1).
- State, `mepc_q` and `cause_q` use `cpu6_dffr`-style registers.
- One sub-module: `cpu6_trap_drain_cnt`, the timeout counter with clear/enable and an expired output.

## Test plan
- Timer interrupt: `mie=1`, `mtie=1`, `tmr_irq_r=1`, `pcE=0x100`, `mtvec=0x80`, ack at t+2.
  - Expect `excp_mepc=0x100` and `excp_cause=0` at t+3, with `trap_pc=0x80`.
  - Expect `stallF` high for 4 cycles.
- External interrupt with `mie=0` → no action. Then raise `mie` → trap taken with `excp_cause=1`.
- Timer and external interrupts both pending → `excp_cause=1`.
- `mret` with `mepc=0x204`, plus an interrupt raised during RDRAIN.
  - Expect `mret_ena` and `trap_pc=0x204` at t+3.
  - The interrupt is taken from IDLE afterwards.
- `mret` and interrupt in the same cycle at `pcE=0x300` → trap path, `excp_mepc=0x300`, no `mret_ena`.
- Ack never arrives → COMMIT after `DRAIN_TIMEOUT` cycles with `drain_err=1`.
- Reset asserted during TDRAIN → no strobes, all outputs 0, `drain_err` cleared.
